// File: rtl/jt49_dcrm_arb.sv
// rtl/jt49_dcrm_arb.sv - round-robin shared DC-removal engine for the three PSG tone channels
// One subtract/average datapath is time-shared; each channel keeps its own 8.8 running average.
module jt49_dcrm_arb #(
    parameter int SHIFT = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [2:0] req,
    input  logic [7:0] din0,
    input  logic [7:0] din1,
    input  logic [7:0] din2,
    input  logic       clr_ovf,
    output logic [7:0] dout0,
    output logic [7:0] dout1,
    output logic [7:0] dout2,
    output logic       dout_valid,
    output logic [1:0] dout_ch,
    output logic [2:0] ovf,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]  state;
    logic [2:0]  pend;
    logic [1:0]  ptr;
    logic [7:0]  smp [3];
    logic [15:0] avg [3];
    logic [7:0]  din_arr [3];

    logic [1:0]  ch;
    logic [7:0]  x;
    logic [15:0] a;
    logic [7:0]  y_r;
    logic [15:0] anew_r;

    logic [1:0]  gnt;
    logic        take;
    logic [2:0]  take_oh;
    logic [2:0]  ovf_set;

    logic signed [8:0]  ydiff;
    logic signed [16:0] d;
    logic [7:0]         y_calc;
    logic [15:0]        anew_calc;

    assign din_arr[0] = din0;
    assign din_arr[1] = din1;
    assign din_arr[2] = din2;

    assign busy = (state != IDLE);

    // First pending channel at or after ptr, wrapping modulo 3
    always_comb begin
        gnt = 2'd0;
        case (ptr)
            2'd0: begin
                if (pend[0])      gnt = 2'd0;
                else if (pend[1]) gnt = 2'd1;
                else              gnt = 2'd2;
            end
            2'd1: begin
                if (pend[1])      gnt = 2'd1;
                else if (pend[2]) gnt = 2'd2;
                else              gnt = 2'd0;
            end
            default: begin
                if (pend[2])      gnt = 2'd2;
                else if (pend[0]) gnt = 2'd0;
                else              gnt = 2'd1;
            end
        endcase
    end

    assign take    = (state == IDLE) && cen && (|pend);
    assign take_oh = take ? (3'b001 << gnt) : 3'b000;
    // A request landing on its own grant edge just refills the slot, not an overrun
    assign ovf_set = req & pend & ~take_oh;

    always_comb begin
        ydiff     = $signed({1'b0, x}) - $signed({1'b0, a[15:8]});
        d         = $signed({1'b0, x, 8'h00}) - $signed({1'b0, a});
        y_calc    = 8'(ydiff >>> 1);
        anew_calc = 16'($signed({1'b0, a}) + (d >>> SHIFT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 3'b000;
            ovf  <= 3'b000;
            for (int i = 0; i < 3; i++) smp[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (req[i]) begin
                    smp[i]  <= din_arr[i];
                    pend[i] <= 1'b1;
                end else if (take_oh[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            ovf <= (clr_ovf ? 3'b000 : ovf) | ovf_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            ch         <= 2'd0;
            x          <= 8'h00;
            a          <= 16'h8000;
            y_r        <= 8'h00;
            anew_r     <= 16'h8000;
            dout0      <= 8'h00;
            dout1      <= 8'h00;
            dout2      <= 8'h00;
            dout_valid <= 1'b0;
            dout_ch    <= 2'd0;
            for (int i = 0; i < 3; i++) avg[i] <= 16'h8000;
        end else begin
            dout_valid <= 1'b0;
            if (cen) begin
                case (state)
                    IDLE: begin
                        if (take) begin
                            ch    <= gnt;
                            x     <= smp[gnt];
                            a     <= avg[gnt];
                            ptr   <= (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        y_r    <= y_calc;
                        anew_r <= anew_calc;
                        state  <= WRITE;
                    end
                    WRITE: begin
                        avg[ch]    <= anew_r;
                        dout_ch    <= ch;
                        dout_valid <= 1'b1;
                        case (ch)
                            2'd0:    dout0 <= y_r;
                            2'd1:    dout1 <= y_r;
                            default: dout2 <= y_r;
                        endcase
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
